conv1_mac_accum: RTL
====================

// Module: conv1_mac_accum
// PURPOSE
// Downstream consumer of the conv-1 window sequencer. Per enabled cycle, takes one 3x3 replicate-padded
// window, its kernel select (dir) and pixel index (dir_counter), and computes a 9-tap dot product
// against the selected signed kernel. Requantizes (shift, ReLU, saturate) and stores into a 3x8x8
// output feature map. Once the sequencer signals completion, streams the map out over valid/ready.
// PARAMETERS
// DATA_W   8   pixel / output width (unsigned)
// W_W      8   weight width (signed, two's complement)
// SHIFT    4   arithmetic right shift applied to the 9-tap sum before ReLU/saturation
// PORTS
// clk        in   1        system clock, all logic on rising edge
// reset      in   1        synchronous, active-high reset
// enb        in   1        window valid this cycle
// dir        in   2        kernel/output channel select, 0..2
// dir_counter in  6        output pixel index {row[5:3],col[2:0]}
// data_done  in   1        sequencer finished all 3 passes (1-cycle pulse)
// window     in   8x3x3    [7:0] window[0:2][0:2], unsigned pixels
// w_we       in   1        weight write strobe
// w_addr     in   5        weight address = dir*9 + r*3 + c, 0..26
// w_data     in   W_W      signed weight value
// out_valid  out  1        stream word valid
// out_ready  in   1        downstream accepts word
// out_data   out  DATA_W   requantized feature value
// out_ch     out  2        channel of out_data, 0..2
// out_idx    out  6        pixel index of out_data, 0..63
// out_last   out  1        high with final word (ch 2, idx 63)
// busy       out  1        state != IDLE
// err        out  1        sticky protocol error
// BEHAVIOUR
// - Reset: state IDLE; out_valid, out_last, busy, err = 0; out_data/ch/idx = 0; all 27 weights = 0;
//   pipeline valids cleared. Feature-map RAM contents are not reset (don't care until rewritten).
// - Sample = enb && !data_done. A cycle with data_done=1 is never a sample, even if enb=1.
// - Pipeline (sub-module): S1 registers 9 products (9-bit zero-extended pixel x signed weight -> 17b signed)
//   plus tag {dir,idx}; S2 registers 21b signed adder-tree sum plus tag; S3 writes requantized value.
//   Sample at cycle t -> fmap[dir][idx] written at edge t+3. One sample per cycle, no stalls.
// - Requantize: v = sum >>> SHIFT (arithmetic); v<0 -> 0; v>255 -> 255; else v[7:0].
// - dir=3 sample: discarded, err set.
// - Weight write (w_we): accepted only in IDLE, reg[w_addr] <= w_data next edge; w_addr>26 ignored.
//   w_we outside IDLE: ignored, err set.
// - FSM:
//   IDLE -> ACCUM on first sample (that sample is processed).
//   ACCUM -> DRAIN on data_done.
//   DRAIN: 3 cycles, pipeline empties -> STREAM.
//   STREAM: emit ch 0..2, idx 0..63 (192 words), ch-major. out_valid held high;
//   out_data/ch/idx/last stable while out_valid && !out_ready; advance only on out_valid && out_ready.
//   Handshake on out_last -> IDLE, out_valid=0 the next cycle.
// - Samples during DRAIN/STREAM: ignored, err set. data_done in IDLE/DRAIN/STREAM: ignored.
// - RAM read for STREAM is prefetched so back-to-back ready gives one word per cycle, no bubbles.
// - err cleared only by reset. reset mid-operation aborts any pass/stream immediately.
// STRUCTURE
// - conv1_pkg: IMG_DIM=8, K_DIM=3, N_CH=3, N_W=27, state_t enum {IDLE,ACCUM,DRAIN,STREAM},
//   typedef window_t (logic [7:0] [0:2][0:2]), SUM_W=21.
// - Sub-module conv1_dot9: S1+S2 (products, adder tree, tag/valid pass-through).
// - Top contains weight regfile, S3 requantize, 192x8 fmap RAM, FSM, stream counters.
// TESTING
// 1. Kernel0 center=1, others 0, SHIFT=0; pixel p(r,c)=r*8+c; 192 samples, then data_done
//    -> ch0 word idx k = k, ch1/ch2 = 0.
// 2. All pixels 255, all weights 127, SHIFT=4 -> sum 291465, >>>4 = 18216 -> all 192 outputs 255.
// 3. Kernel1 all -1, pixels 10 -> ch1 outputs 0 (ReLU); kernel2 all 1, pixels 16, SHIFT=4 -> ch2 = 9.
// 4. Random out_ready (50%) in STREAM -> 192 words in order, no drop/duplicate, data held while stalled;
//    out_last only on word 191.
// 5. enb=1 with data_done=1 at dir=0, idx=0 -> fmap[0][0] keeps prior value.
//    w_we during ACCUM -> weight unchanged, err=1.
// 6. reset asserted at word 100 of STREAM -> next cycle out_valid=0, busy=0, weights 0;
//    new full pass streams correctly.

Source files
------------

// File: rtl/conv1_pkg.sv
// Shared types and geometry for the conv-1 MAC/accumulate stage.
package conv1_pkg;
  localparam int unsigned IMG_DIM = 8;
  localparam int unsigned K_DIM   = 3;
  localparam int unsigned N_CH    = 3;
  localparam int unsigned N_W     = 27;
  localparam int unsigned N_TAP   = K_DIM * K_DIM;
  localparam int unsigned N_PIX   = IMG_DIM * IMG_DIM;
  localparam int unsigned N_WORDS = N_CH * N_PIX;
  localparam int unsigned SUM_W   = 21;

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN, STREAM} state_t;

  typedef logic [0:K_DIM-1][0:K_DIM-1][7:0] window_t;

  typedef struct packed {
    logic [1:0] dir;
    logic [5:0] idx;
  } tag_t;
endpackage

// File: rtl/conv1_dot9.sv
// Two-stage 9-tap dot product: registered products, then registered sum.
module conv1_dot9
  import conv1_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned W_W    = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_valid,
  input  tag_t                          in_tag,
  input  window_t                       win,
  input  logic [N_TAP-1:0][W_W-1:0]     wts,
  output logic                          out_valid,
  output tag_t                          out_tag,
  output logic signed [SUM_W-1:0]       out_sum
);
  localparam int unsigned PROD_W = DATA_W + 1 + W_W;

  logic signed [PROD_W-1:0] prod_d [N_TAP];
  logic signed [PROD_W-1:0] prod_q [N_TAP];
  logic signed [SUM_W-1:0]  sum_d, sum_q;
  logic                     s1_v_q, s2_v_q;
  tag_t                     s1_tag_q, s2_tag_q;

  // Pixels are zero-extended so they stay non-negative in the signed product.
  for (genvar r = 0; r < K_DIM; r++) begin : g_r
    for (genvar c = 0; c < K_DIM; c++) begin : g_c
      logic signed [PROD_W-1:0] px, wx;
      assign px = PROD_W'($signed({1'b0, win[r][c]}));
      assign wx = PROD_W'($signed(wts[r*K_DIM+c]));
      assign prod_d[r*K_DIM+c] = px * wx;
    end
  end

  always_comb begin
    sum_d = '0;
    for (int unsigned i = 0; i < N_TAP; i++) sum_d = sum_d + SUM_W'(prod_q[i]);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_v_q <= 1'b0;
      s2_v_q <= 1'b0;
    end else begin
      s1_v_q <= in_valid;
      s2_v_q <= s1_v_q;
    end
    s1_tag_q <= in_tag;
    prod_q   <= prod_d;
    s2_tag_q <= s1_tag_q;
    sum_q    <= sum_d;
  end

  assign out_valid = s2_v_q;
  assign out_tag   = s2_tag_q;
  assign out_sum   = sum_q;
endmodule

// File: rtl/conv1_mac_accum.sv
// Conv-1 MAC stage: weight regfile, dot-product pipeline, requantize, 3x8x8 map, streaming out.
module conv1_mac_accum
  import conv1_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned W_W    = 8,
  parameter int unsigned SHIFT  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enb,
  input  logic [1:0]        dir,
  input  logic [5:0]        dir_counter,
  input  logic              data_done,
  input  window_t           window,
  input  logic              w_we,
  input  logic [4:0]        w_addr,
  input  logic [W_W-1:0]    w_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [1:0]        out_ch,
  output logic [5:0]        out_idx,
  output logic              out_last,
  output logic              busy,
  output logic              err
);
  localparam logic signed [SUM_W-1:0] QMAX = SUM_W'((1 << DATA_W) - 1);

  state_t                  state_q, state_d;
  logic [1:0]              cnt_q, cnt_d;
  logic [7:0]              ptr_q, ptr_d, rd_addr;
  logic                    err_q, err_d, rd_en;
  logic [W_W-1:0]          w_q [N_W];
  logic [N_TAP-1:0][W_W-1:0] wk [N_CH];
  logic [N_TAP-1:0][W_W-1:0] wsel;
  logic [DATA_W-1:0]       fmap [N_WORDS];
  logic [DATA_W-1:0]       rd_q, q;
  logic                    sample, accept, s2_v;
  tag_t                    in_tag, s2_tag;
  logic signed [SUM_W-1:0] s2_sum, shifted;

  assign sample = enb && !data_done;
  assign accept = sample && (dir != 2'd3) && (state_q == IDLE || state_q == ACCUM);
  assign in_tag = {dir, dir_counter};

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < N_W; i++) w_q[i] <= '0;
    end else if (w_we && state_q == IDLE && w_addr < 5'(N_W)) begin
      w_q[w_addr] <= w_data;
    end
  end

  for (genvar ch = 0; ch < N_CH; ch++) begin : g_ch
    for (genvar t = 0; t < N_TAP; t++) begin : g_t
      assign wk[ch][t] = w_q[ch*N_TAP+t];
    end
  end
  assign wsel = (dir == 2'd3) ? '0 : wk[dir];

  conv1_dot9 #(.DATA_W(DATA_W), .W_W(W_W)) u_dot9 (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (accept),
    .in_tag    (in_tag),
    .win       (window),
    .wts       (wsel),
    .out_valid (s2_v),
    .out_tag   (s2_tag),
    .out_sum   (s2_sum)
  );

  always_comb begin
    shifted = s2_sum >>> SHIFT;
    if (shifted[SUM_W-1])   q = '0;
    else if (shifted > QMAX) q = '1;
    else                     q = shifted[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (s2_v) fmap[{s2_tag.dir, s2_tag.idx}] <= q;
  end

  // Read register always holds the word at ptr_q, so a handshake can advance every cycle.
  always_ff @(posedge clk) begin
    if (reset)      rd_q <= '0;
    else if (rd_en) rd_q <= fmap[rd_addr];
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    err_d   = err_q;
    rd_en   = 1'b0;
    rd_addr = ptr_q;
    if (sample && dir == 2'd3)                            err_d = 1'b1;
    if (w_we && state_q != IDLE)                          err_d = 1'b1;
    if (sample && (state_q == DRAIN || state_q == STREAM)) err_d = 1'b1;
    case (state_q)
      IDLE:  if (accept) state_d = ACCUM;
      ACCUM: if (data_done) begin
        state_d = DRAIN;
        cnt_d   = '0;
      end
      DRAIN: begin
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd2) begin
          state_d = STREAM;
          ptr_d   = '0;
          rd_en   = 1'b1;
          rd_addr = '0;
        end
      end
      STREAM: if (out_ready) begin
        if (ptr_q == 8'(N_WORDS - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end else begin
          ptr_d   = ptr_q + 8'd1;
          rd_en   = 1'b1;
          rd_addr = ptr_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
    end
  end

  assign out_valid = (state_q == STREAM);
  assign out_last  = out_valid && (ptr_q == 8'(N_WORDS - 1));
  assign out_data  = rd_q;
  assign out_ch    = ptr_q[7:6];
  assign out_idx   = ptr_q[5:0];
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
endmodule
